alu_arbiter: RTL and testbench

- Shares the single 64-bit ALU (alu64bit) between two requesters, e.g. the execute stage (port 0) and an address-generation helper (port 1).
- Arbitrates round-robin and drives the ALU operands and control from registers.
- Captures the ALU result and overflow, returns them over a valid/ready response channel, and maintains the ZF/SF/OF condition-code register.

---
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational W-bit ALU between two requesters.
// Registers operands, captures result/overflow, returns them on a response channel, keeps ZF/SF/OF.
module alu_arbiter #(
  parameter int unsigned W         = 64,
  parameter bit          INIT_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_set_cc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_set_cc,
  output logic [1:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_ovf,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid and payload stable until ready; ready is only raised in IDLE,
  // and the response payload is held stable while rsp_valid=1 and rsp_ready=0.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           set_cc_q, set_cc_d;
  logic           id_q, id_d;
  logic [W-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic           zf_q, zf_d;
  logic           sf_q, sf_d;
  logic           of_q, of_d;

  logic           grant_id;
  logic           grant_vld;
  logic           gated_ovf;

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_q;
    else                          grant_id = req1_valid;
  end

  // Logic ops never report overflow, whatever the ALU drives.
  assign gated_ovf = alu_ovf & ~op_q[1];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    set_cc_d   = set_cc_q;
    id_d       = id_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    zf_d       = zf_q;
    sf_d       = sf_q;
    of_d       = of_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op_d       = grant_id ? req1_op     : req0_op;
          a_d        = grant_id ? req1_a      : req0_a;
          b_d        = grant_id ? req1_b      : req0_b;
          set_cc_d   = grant_id ? req1_set_cc : req0_set_cc;
          id_d       = grant_id;
          last_d     = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d = alu_out;
        ovf_d = gated_ovf;
        if (set_cc_q) begin
          zf_d = (alu_out == '0);
          sf_d = alu_out[W-1];
          of_d = gated_ovf;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= ~INIT_PRIO;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      set_cc_q <= 1'b0;
      id_q     <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      set_cc_q <= set_cc_d;
      id_q     <= id_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  assign alu_ctrl   = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_ovf    = ovf_q;
  assign cc_zf      = zf_q;
  assign cc_sf      = sf_q;
  assign cc_of      = of_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU, an expected-response queue
// and a condition-code model.
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int EW = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req0_ready, req0_set_cc = 1'b0;
  logic [1:0]   req0_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic         req1_valid = 1'b0, req1_ready, req1_set_cc = 1'b0;
  logic [1:0]   req1_op = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_ovf;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_result;
  logic         cc_zf, cc_sf, cc_of, busy;
  logic [1:0]   dbg_state;
  logic         force_ovf = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  logic          exp_zf = 1'b0, exp_sf = 1'b0, exp_of = 1'b0;
  int            acc_id_q[$];
  int            acc_cyc_q[$];
  int            last_acc_cyc = 0;
  int            rise_cnt = 0;
  logic          prev_rv = 1'b0;
  logic [W-1:0]  last_res;
  logic          last_ovf;

  alu_arbiter #(.W(W), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_set_cc(req1_set_cc),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference arithmetic: W-bit two's complement, signed overflow for add/sub only
  function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         v;
    v = 1'b0;
    case (op)
      2'd0: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      2'd1: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {v, r};
  endfunction

  // behavioural ALU; force_ovf lets a logic op see a spurious overflow
  always_comb begin
    logic [W:0] t;
    t       = ref_op(alu_ctrl, alu_a, alu_b);
    alu_out = t[W-1:0];
    alu_ovf = t[W] | force_ovf;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on accepted request, pop and compare on response handshake
  always @(negedge clk) begin
    logic [W:0] t;
    logic       id;
    logic       vo;
    logic [EW-1:0] e;
    if (req0_valid === 1'b1 && req0_ready === 1'b1) begin
      t  = ref_op(req0_op, req0_a, req0_b);
      vo = t[W] & ~req0_op[1];
      exp_q.push_back({1'b0, vo, t[W-1:0]});
      if (req0_set_cc) begin exp_zf = (t[W-1:0] == '0); exp_sf = t[W-1]; exp_of = vo; end
      acc_id_q.push_back(0); acc_cyc_q.push_back(cyc); last_acc_cyc = cyc;
    end
    if (req1_valid === 1'b1 && req1_ready === 1'b1) begin
      t  = ref_op(req1_op, req1_a, req1_b);
      vo = t[W] & ~req1_op[1];
      exp_q.push_back({1'b1, vo, t[W-1:0]});
      if (req1_set_cc) begin exp_zf = (t[W-1:0] == '0); exp_sf = t[W-1]; exp_of = vo; end
      acc_id_q.push_back(1); acc_cyc_q.push_back(cyc); last_acc_cyc = cyc;
    end
    if (rsp_valid === 1'b1 && prev_rv !== 1'b1) begin
      rise_cnt++;
      check("rsp_latency", cyc, last_acc_cyc + 2);
    end
    prev_rv = rsp_valid;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        id = e[W+1];
        check("rsp_id", rsp_id, id);
        check("rsp_result", rsp_result, e[W-1:0]);
        check("rsp_ovf", rsp_ovf, e[W]);
        check("cc_zf", cc_zf, exp_zf);
        check("cc_sf", cc_sf, exp_sf);
        check("cc_of", cc_of, exp_of);
        last_res = rsp_result;
        last_ovf = rsp_ovf;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    exp_q.delete();
    exp_zf = 1'b0; exp_sf = 1'b0; exp_of = 1'b0;
  endtask

  task automatic drive(input bit p, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit cc);
    if (p) begin req1_op = op; req1_a = a; req1_b = b; req1_set_cc = cc; req1_valid = 1'b1; end
    else   begin req0_op = op; req0_a = a; req0_b = b; req0_set_cc = cc; req0_valid = 1'b1; end
  endtask

  // returns one cycle after the accepting edge (DUT in EXEC)
  task automatic issue(input bit p, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit cc);
    bit got;
    got = 1'b0;
    drive(p, op, a, b, cc);
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((p ? req1_ready : req0_ready) === 1'b1) begin got = 1'b1; break; end
      step();
    end
    if (got) step();
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    check("issue_accepted", got, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) begin done = 1'b1; break; end
      step();
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_result"}, rsp_result, 0);
    check({pfx, "_rsp_ovf"}, rsp_ovf, 0);
    check({pfx, "_cc"}, {cc_zf, cc_sf, cc_of}, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_alu_ctrl"}, alu_ctrl, 0);
    check({pfx, "_alu_a"}, alu_a, 0);
    check({pfx, "_alu_b"}, alu_b, 0);
    check({pfx, "_ready"}, {req0_ready, req1_ready}, 0);
  endtask

  initial begin
    int exp_g[4];
    int rc;
    exp_g = '{0, 1, 0, 1};

    // reset state
    do_reset();
    check_idle_zero("reset");

    // add with overflow
    issue(1'b0, 2'd0, 64'h7fff_ffff_ffff_ffff, 64'd1, 1'b1);
    drain();
    check("add_result", last_res, 64'h8000_0000_0000_0000);
    check("add_ovf", last_ovf, 1'b1);
    check("add_cc", {cc_zf, cc_sf, cc_of}, 3'b011);

    // sub to zero, then sub without cc update
    issue(1'b1, 2'd1, 64'd69, 64'd69, 1'b1);
    drain();
    check("sub0_result", last_res, 64'd0);
    check("sub0_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    issue(1'b1, 2'd1, 64'd69, 64'd420, 1'b0);
    drain();
    check("sub_neg_result", last_res, -64'sd351);
    check("sub_neg_cc_kept", {cc_zf, cc_sf, cc_of}, 3'b100);

    // contention from fresh reset
    do_reset();
    acc_id_q.delete(); acc_cyc_q.delete();
    drive(1'b0, 2'd0, 64'd10, 64'd20, 1'b0);
    drive(1'b1, 2'd1, 64'd100, 64'd1, 1'b0);
    for (int i = 0; i < 13; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("cont_count_ge4", acc_id_q.size() >= 4, 1'b1);
    if (acc_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), acc_id_q[i], exp_g[i]);
      for (int i = 1; i < 4; i++) check($sformatf("cont_gap%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 3);
    end

    // logic ops; xor with spurious ALU overflow
    issue(1'b0, 2'd2, 64'd4, 64'd12, 1'b1);
    drain();
    check("and_result", last_res, 64'd4);
    check("and_ovf", last_ovf, 1'b0);
    force_ovf = 1'b1;
    issue(1'b1, 2'd3, 64'd3, -64'sd1, 1'b1);
    drain();
    force_ovf = 1'b0;
    check("xor_result", last_res, -64'sd4);
    check("xor_ovf", last_ovf, 1'b0);
    check("xor_cc", {cc_zf, cc_sf, cc_of}, 3'b010);

    // response stall
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, 64'd5, 64'd6, 1'b0);
    step();
    drive(1'b1, 2'd2, 64'd1, 64'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_result", rsp_result, 64'd11);
      check("stall_ready", {req0_ready, req1_ready}, 2'b00);
      check("stall_busy", busy, 1'b1);
      step();
    end
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    step();
    check("stall_release_idle", busy, 1'b0);
    check("stall_released_result", last_res, 64'd11);
    drain();

    // reset while in EXEC; last grant before reset was port 0
    issue(1'b0, 2'd0, 64'd1, 64'd2, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_zf = 1'b0; exp_sf = 1'b0; exp_of = 1'b0;
    rc = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      check("rst_exec_no_valid", rsp_valid, 1'b0);
      step();
    end
    check("rst_exec_no_rise", rise_cnt, rc);
    check_idle_zero("rst_exec");
    drive(1'b0, 2'd0, 64'd7, 64'd8, 1'b1);
    drive(1'b1, 2'd0, 64'd9, 64'd9, 1'b1);
    #1;
    check("rst_exec_prio", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("rst_exec_result", last_res, 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
